// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with programmable weights and packet locking.
// A grant is held until the packet completes; each completed packet costs one credit.
module wrr_lock_arbiter #(
    parameter int               N               = 4,
    parameter int               W               = 3,
    parameter logic [N*W-1:0]   DEFAULT_WEIGHTS = {3'd4, 3'd2, 3'd1, 3'd1},
    parameter bit               PKT_LOCK        = 1'b1,
    localparam int              IW              = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  req_last,
    input  logic          ready,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [W-1:0]  cfg_weight,
    output logic          refill
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          refill_q, refill_d;
    logic [W-1:0]  weight_q [N];
    logic [W-1:0]  weight_d [N];
    logic [W-1:0]  credit_q [N];
    logic [W-1:0]  credit_d [N];

    logic [N-1:0]  eligible;
    logic [N-1:0]  can_refill;
    logic          found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] scan_idx;
    logic          beat;
    logic          done;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            eligible[k]   = req[k] && (credit_q[k] != '0);
            can_refill[k] = req[k] && (weight_q[k] != '0);
        end
    end

    // Circular first-eligible search starting at the round-robin pointer.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = IW'((int'(ptr_q) + i) % N);
            if (!found && eligible[scan_idx]) begin
                found    = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    assign beat = ready && req[grant_id_q];
    assign done = beat && (req_last[grant_id_q] || !PKT_LOCK);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        refill_d   = 1'b0;
        credit_d   = credit_q;
        weight_d   = weight_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    grant_id_d        = pick_idx;
                    state_d           = BUSY;
                end else if (can_refill != '0) begin
                    credit_d = weight_q;
                    refill_d = 1'b1;
                end
            end
            BUSY: begin
                if (done) begin
                    if (credit_q[grant_id_q] != '0) begin
                        credit_d[grant_id_q] = credit_q[grant_id_q] - 1'b1;
                    end
                    ptr_d      = (int'(grant_id_q) == N - 1) ? '0 : grant_id_q + 1'b1;
                    grant_d    = '0;
                    grant_id_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Weight writes only land in weight_q; credits pick them up at the next refill.
        if (cfg_we && (int'(cfg_idx) < N)) begin
            weight_d[cfg_idx] = cfg_weight;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            refill_q   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                weight_q[k] <= DEFAULT_WEIGHTS[k*W +: W];
                credit_q[k] <= DEFAULT_WEIGHTS[k*W +: W];
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            refill_q   <= refill_d;
            weight_q   <= weight_d;
            credit_q   <= credit_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = grant_id_q;
    assign refill      = refill_q;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Directed bench for wrr_lock_arbiter: frame order, packet locking, stalls,
// weight reprogramming, zero-weight ports and mid-packet reset.
module tb_wrr_lock_arbiter;

    localparam int N  = 4;
    localparam int W  = 3;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  req_last;
    logic          ready;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [W-1:0]  cfg_weight;
    logic          refill;

    int n_checks = 0;
    int n_errors = 0;

    wrr_lock_arbiter #(
        .N(N), .W(W), .DEFAULT_WEIGHTS({3'd4, 3'd2, 3'd1, 3'd1}), .PKT_LOCK(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_last(req_last), .ready(ready),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight), .refill(refill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full packet slot with ready=1 and last=1: grant cycle, then idle cycle.
    task automatic expect_grant(input string tag, input int id);
        logic [N-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        tick();
        check_eq({tag, "_id"}, 32'(grant_id), 32'(id));
        check_eq({tag, "_onehot"}, 32'(grant), 32'(oh));
        check_eq({tag, "_norefill"}, 32'(refill), 0);
        tick();
        check_eq({tag, "_gap"}, 32'(grant_valid), 0);
    endtask

    task automatic expect_refill(input string tag);
        tick();
        check_eq({tag, "_refill"}, 32'(refill), 1);
        check_eq({tag, "_nogrant"}, 32'(grant_valid), 0);
    endtask

    int seq_default [8]  = '{0, 1, 2, 3, 2, 3, 3, 3};
    int seq_drain   [6]  = '{0, 2, 3, 2, 3, 3};
    int seq_new     [12] = '{0, 1, 2, 3, 0, 2, 3, 0, 3, 0, 3, 0};

    initial begin
        rst = 1'b1; req = '0; req_last = '0; ready = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
        tick();
        tick();
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_gvalid", 32'(grant_valid), 0);
        check_eq("rst_gid", 32'(grant_id), 0);
        check_eq("rst_refill", 32'(refill), 0);

        // Default weights, everyone requesting single-beat packets.
        rst = 1'b0; req = 4'hf; req_last = 4'hf; ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) expect_grant($sformatf("t1_r%0d_g%0d", r, i), seq_default[i]);
            expect_refill($sformatf("t1_r%0d", r));
        end
        req = '0;

        // Port1 three-beat packet, port0 joins mid-packet, ready toggles.
        req = 4'b0010; ready = 1'b0; req_last = '0;
        tick();
        check_eq("t2_grant1", 32'(grant_id), 1);
        req = 4'b0011;
        for (int b = 0; b < 4; b++) begin
            ready = (b % 2 == 0);
            tick();
            check_eq($sformatf("t2_hold%0d", b), 32'(grant), 32'(4'b0010));
        end
        check_eq("t2_credit_mid", 32'(dut.credit_q[1]), 1);
        ready = 1'b1; req_last = 4'b0010;
        tick();
        check_eq("t2_release", 32'(grant_valid), 0);
        check_eq("t2_credit1", 32'(dut.credit_q[1]), 0);
        check_eq("t2_credit0", 32'(dut.credit_q[0]), 1);
        check_eq("t2_ptr", 32'(dut.ptr_q), 2);
        req = '0; ready = 1'b0;

        // Long stall while port3 holds the grant.
        req = 4'b1000; req_last = 4'hf;
        tick();
        check_eq("t3_grant3", 32'(grant_id), 3);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq($sformatf("t3_hold%0d", c), 32'(grant), 32'(4'b1000));
            check_eq($sformatf("t3_refill%0d", c), 32'(refill), 0);
            check_eq($sformatf("t3_credit%0d", c), 32'(dut.credit_q[3]), 4);
        end
        ready = 1'b1;
        tick();
        check_eq("t3_done", 32'(grant_valid), 0);
        check_eq("t3_credit_after", 32'(dut.credit_q[3]), 3);
        req = '0;

        // Reprogram port0 weight mid-frame; current credit is untouched.
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_weight = 3'd5;
        tick();
        cfg_we = 1'b0;
        check_eq("t4_credit0_kept", 32'(dut.credit_q[0]), 1);
        check_eq("t4_weight0", 32'(dut.weight_q[0]), 5);
        req = 4'hf; req_last = 4'hf; ready = 1'b1;
        for (int i = 0; i < 6; i++) expect_grant($sformatf("t4_drain%0d", i), seq_drain[i]);
        expect_refill("t4_a");
        check_eq("t4_credit0_new", 32'(dut.credit_q[0]), 5);
        for (int i = 0; i < 12; i++) expect_grant($sformatf("t4_new%0d", i), seq_new[i]);
        expect_refill("t4_b");
        req = '0;

        // Zero weight on port2: it drains its credits and then is starved without refills.
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_weight = 3'd0;
        tick();
        cfg_we = 1'b0;
        check_eq("t5_weight2", 32'(dut.weight_q[2]), 0);
        req = 4'b0100;
        expect_grant("t5_drain0", 2);
        expect_grant("t5_drain1", 2);
        for (int c = 0; c < 8; c++) begin
            tick();
            check_eq($sformatf("t5_nogrant%0d", c), 32'(grant_valid), 0);
            check_eq($sformatf("t5_norefill%0d", c), 32'(refill), 0);
        end
        req = '0;

        // Reset in the middle of a four-beat packet on port3.
        req = 4'b1000; req_last = '0; ready = 1'b1;
        tick();
        check_eq("t6_grant3", 32'(grant_id), 3);
        tick();
        tick();
        check_eq("t6_still3", 32'(grant), 32'(4'b1000));
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_grant", 32'(grant), 0);
        check_eq("t6_rst_gvalid", 32'(grant_valid), 0);
        check_eq("t6_rst_gid", 32'(grant_id), 0);
        check_eq("t6_rst_refill", 32'(refill), 0);
        tick();
        check_eq("t6_weight2_restored", 32'(dut.weight_q[2]), 2);
        check_eq("t6_credit3_restored", 32'(dut.credit_q[3]), 4);
        rst = 1'b0; req = 4'hf; req_last = 4'hf;
        tick();
        check_eq("t6_first_after_rst", 32'(grant_id), 0);
        check_eq("t6_first_valid", 32'(grant_valid), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
